// File: rtl/clk_rst_trace_pkg.sv
// clk_rst_trace_pkg: shared FSM states, mode encodings and counter width for the trace engine
package clk_rst_trace_pkg;
  localparam int CNT_W = 16;
  localparam logic MODE_DUMP = 1'b0;
  localparam logic MODE_READ = 1'b1;
  typedef enum logic [1:0] {IDLE, DUMP, RD_INIT, RD_RUN} state_t;
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/clk_rst_trace_engine_if.sv
// clk_rst_trace_engine_if: dump (out) and replay (in) event streams; master is the engine side
interface clk_rst_trace_engine_if #(parameter int NUM_CH = 4, parameter int TS_W = 48);
  logic                   ev_out_valid;
  logic                   ev_out_ready;
  logic [TS_W+NUM_CH-1:0] ev_out_data;
  logic                   ev_in_valid;
  logic                   ev_in_ready;
  logic [TS_W+NUM_CH-1:0] ev_in_data;
  modport master (output ev_out_valid, ev_out_data, ev_in_ready, input ev_out_ready, ev_in_valid, ev_in_data);
  modport slave (input ev_out_valid, ev_out_data, ev_in_ready, output ev_out_ready, ev_in_valid, ev_in_data);
endinterface

// File: rtl/clk_rst_trace_fifo.sv
// clk_rst_trace_fifo: first-word-fall-through FIFO with flush; a full FIFO still accepts a push alongside a pop
module clk_rst_trace_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout = mem[rd_ptr[AW-1:0]];
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  // when full, the write slot is the head being popped this cycle, already read out combinationally
  always_ff @(posedge clk)
    if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= din;
endmodule

// File: rtl/clk_rst_trace_engine.sv
// clk_rst_trace_engine: records channel changes as timestamped events (dump) or replays
// timestamped events onto sig_out (read); rst is asynchronous active-low
module clk_rst_trace_engine
  import clk_rst_trace_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int TS_W       = 48,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                mode,
  input  logic [NUM_CH-1:0]   sig_in,
  clk_rst_trace_engine_if.master io,
  output logic [NUM_CH-1:0]   sig_out,
  output logic [TS_W-1:0]     clkcnt,
  output logic [CNT_W-1:0]    ovf_cnt,
  output logic [CNT_W-1:0]    late_cnt,
  output logic                busy
);
  state_t state, state_nxt;
  logic en_q, first, start, flush, push, pop, full, empty, in_ready, in_fire;
  logic [NUM_CH-1:0] prev;
  logic [TS_W-1:0] ev_ts;
  logic [NUM_CH-1:0] ev_val;
  assign ev_ts = io.ev_in_data[TS_W+NUM_CH-1:NUM_CH];
  assign ev_val = io.ev_in_data[NUM_CH-1:0];
  assign flush = start && mode == MODE_DUMP;
  assign busy = state != IDLE;
  assign io.ev_out_valid = !empty;
  assign io.ev_in_ready = in_ready;
  clk_rst_trace_fifo #(.WIDTH(TS_W+NUM_CH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .flush(flush), .push(push), .din({clkcnt, sig_in}),
    .pop(pop), .dout(io.ev_out_data), .full(full), .empty(empty)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    start = en && !en_q && state == IDLE;
    in_ready = state == RD_INIT || (state == RD_RUN && io.ev_in_valid && clkcnt >= ev_ts);
    in_fire = in_ready && io.ev_in_valid;
    push = state == DUMP && (first || sig_in != prev);
    pop = !empty && io.ev_out_ready;
    state_nxt = !en ? IDLE : start ? (mode == MODE_READ ? RD_INIT : DUMP) : (state == RD_INIT && in_fire) ? RD_RUN : state;
  end
  // en_q resets high so an en already high at reset release is not taken as a rise
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      en_q <= 1'b1;
      first <= 1'b0;
      prev <= '0;
      sig_out <= '0;
      clkcnt <= '0;
      ovf_cnt <= '0;
      late_cnt <= '0;
    end else begin
      en_q <= en;
      first <= flush;
      if (state == DUMP) prev <= sig_in;
      if (in_fire) sig_out <= ev_val;
      clkcnt <= start ? '0 : (state == RD_INIT && in_fire) ? ev_ts : (state == DUMP || state == RD_RUN) ? clkcnt + 1'b1 : clkcnt;
      ovf_cnt <= start ? '0 : (push && full && !pop) ? sat_inc(ovf_cnt) : ovf_cnt;
      late_cnt <= start ? '0 : (in_fire && state == RD_RUN && ev_ts < clkcnt) ? sat_inc(late_cnt) : late_cnt;
    end
endmodule

// File: tb/tb_clk_rst_trace_engine.sv
// tb_clk_rst_trace_engine: directed vectors for dump, overflow, replay, reset abort and timestamp wrap
module tb_clk_rst_trace_engine;
  localparam int NC = 4;
  localparam int TW = 48;
  localparam int DW = TW + NC;
  typedef struct { int cyc; logic [NC-1:0] sig; logic [DW-1:0] ev; } dvec_t;
  typedef struct { logic [TW-1:0] ts; logic [NC-1:0] val; int wt; logic [TW-1:0] cnt; logic [15:0] late; } rvec_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en = 1'b0;
  logic mode = 1'b0;
  logic [NC-1:0] sig_in = '0;
  logic [NC-1:0] sig_out;
  logic [TW-1:0] clkcnt;
  logic [15:0] ovf_cnt, late_cnt;
  logic busy;
  logic en8 = 1'b0;
  logic [NC-1:0] sig8 = '0;
  logic [NC-1:0] sig_out8;
  logic [7:0] clkcnt8;
  logic [15:0] ovf8, late8;
  logic busy8;
  int checks = 0;
  int errors = 0;
  logic [DW-1:0] q[$];
  logic [11:0] q8[$];
  dvec_t dv[4];
  rvec_t rv[3];
  always #5 clk = ~clk;
  clk_rst_trace_engine_if #(.NUM_CH(NC), .TS_W(TW)) io();
  clk_rst_trace_engine_if #(.NUM_CH(NC), .TS_W(8)) io8();
  clk_rst_trace_engine #(.NUM_CH(NC), .TS_W(TW), .FIFO_DEPTH(16)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sig_in(sig_in), .io(io),
    .sig_out(sig_out), .clkcnt(clkcnt), .ovf_cnt(ovf_cnt), .late_cnt(late_cnt), .busy(busy)
  );
  clk_rst_trace_engine #(.NUM_CH(NC), .TS_W(8), .FIFO_DEPTH(16)) dut8 (
    .clk(clk), .rst(rst), .en(en8), .mode(1'b0), .sig_in(sig8), .io(io8),
    .sig_out(sig_out8), .clkcnt(clkcnt8), .ovf_cnt(ovf8), .late_cnt(late8), .busy(busy8)
  );
  always @(negedge clk) begin
    if (io.ev_out_valid && io.ev_out_ready) q.push_back(io.ev_out_data);
    if (io8.ev_out_valid && io8.ev_out_ready) q8.push_back(io8.ev_out_data);
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask
  initial begin
    int n;
    io.ev_out_ready = 1'b0; io.ev_in_valid = 1'b0; io.ev_in_data = '0;
    io8.ev_out_ready = 1'b1; io8.ev_in_valid = 1'b0; io8.ev_in_data = '0;
    dv[0] = '{0, 4'h3, {48'd0, 4'h3}};
    dv[1] = '{5, 4'h2, {48'd5, 4'h2}};
    dv[2] = '{6, 4'hD, {48'd6, 4'hD}};
    dv[3] = '{9, 4'h0, {48'd9, 4'h0}};
    rv[0] = '{48'd100, 4'hF, 0, 48'd100, 16'd0};
    rv[1] = '{48'd103, 4'h0, 3, 48'd104, 16'd0};
    rv[2] = '{48'd102, 4'h5, 0, 48'd105, 16'd1};
    repeat (3) step();
    chk("rst_busy", busy, 0);
    chk("rst_clkcnt", clkcnt, 0);
    chk("rst_sig_out", sig_out, 0);
    chk("rst_ovf", ovf_cnt, 0);
    chk("rst_late", late_cnt, 0);
    chk("rst_out_valid", io.ev_out_valid, 0);
    chk("rst_in_ready", io.ev_in_ready, 0);
    rst = 1'b1;
    step();
    io.ev_out_ready = 1'b1; sig_in = 4'h3; en = 1'b1;
    step();
    chk("dump_busy", busy, 1);
    for (int c = 0; c < 12; c++) begin
      chk($sformatf("dump_cnt%0d", c), clkcnt, 64'(c));
      foreach (dv[i]) if (dv[i].cyc == c) sig_in = dv[i].sig;
      step();
    end
    en = 1'b0;
    step();
    chk("dump_to_idle", busy, 0);
    repeat (3) step();
    chk("idle_cnt_hold", clkcnt, 13);
    chk("dump_ev_count", 64'(q.size()), 4);
    foreach (dv[i]) chk($sformatf("dump_ev%0d", i), q[i], dv[i].ev);
    q.delete();
    io.ev_out_ready = 1'b0; sig_in = 4'h0; en = 1'b1;
    step();
    step();
    for (int i = 1; i <= 20; i++) begin
      sig_in = 4'(i);
      step();
    end
    chk("ovf_cnt", ovf_cnt, 5);
    chk("ovf_valid", io.ev_out_valid, 1);
    sig_in = 4'h5; io.ev_out_ready = 1'b1;
    step();
    io.ev_out_ready = 1'b0;
    chk("ovf_pop_push", ovf_cnt, 5);
    chk("ovf_pop_cnt", 64'(q.size()), 1);
    chk("ovf_init_ev", q[0], {48'd0, 4'h0});
    en = 1'b0;
    step();
    io.ev_out_ready = 1'b1;
    repeat (20) step();
    chk("drain_count", 64'(q.size()), 17);
    chk("drain_ev1", q[1], {48'd1, 4'h1});
    chk("drain_ev15", q[15], {48'd15, 4'hF});
    chk("drain_ev16", q[16], {48'd21, 4'h5});
    chk("drain_empty", io.ev_out_valid, 0);
    chk("drain_ovf_hold", ovf_cnt, 5);
    mode = 1'b1; en = 1'b1;
    step();
    chk("rd_busy", busy, 1);
    chk("rd_cnt_clr", clkcnt, 0);
    chk("rd_ovf_clr", ovf_cnt, 0);
    chk("rd_init_ready", io.ev_in_ready, 1);
    foreach (rv[i]) begin
      io.ev_in_data = {rv[i].ts, rv[i].val}; io.ev_in_valid = 1'b1;
      #1;
      n = 0;
      while (!io.ev_in_ready && n < 300) begin
        step();
        n++;
      end
      chk($sformatf("rd_wait%0d", i), 64'(n), 64'(rv[i].wt));
      step();
      chk($sformatf("rd_sig%0d", i), sig_out, rv[i].val);
      chk($sformatf("rd_cnt%0d", i), clkcnt, rv[i].cnt);
      chk($sformatf("rd_late%0d", i), late_cnt, rv[i].late);
    end
    io.ev_in_valid = 1'b0;
    step();
    chk("rd_idle_ready", io.ev_in_ready, 0);
    chk("rd_sig_hold", sig_out, 4'h5);
    rst = 1'b0;
    #1;
    chk("abort_sig", sig_out, 0);
    chk("abort_busy", busy, 0);
    chk("abort_cnt", clkcnt, 0);
    step();
    step();
    rst = 1'b1; io.ev_in_valid = 1'b1;
    repeat (4) step();
    chk("en_held_idle", busy, 0);
    chk("en_held_ready", io.ev_in_ready, 0);
    io.ev_in_valid = 1'b0; en = 1'b0;
    step();
    en = 1'b1;
    step();
    chk("fresh_rise", busy, 1);
    en = 1'b0;
    step();
    chk("fresh_stop", busy, 0);
    sig8 = 4'h1; en8 = 1'b1;
    step();
    for (int c = 0; c < 300; c++) begin
      if (c == 250) sig8 = 4'h2;
      if (c == 260) sig8 = 4'h3;
      step();
    end
    chk("wrap_cnt", clkcnt8, 44);
    en8 = 1'b0;
    repeat (3) step();
    chk("wrap_ev_count", 64'(q8.size()), 3);
    chk("wrap_ev0", q8[0], {8'd0, 4'h1});
    chk("wrap_ev1", q8[1], {8'd250, 4'h2});
    chk("wrap_ev2", q8[2], {8'd4, 4'h3});
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/clk_rst_trace_engine.md
CLK_RST_TRACE_ENGINE -- requirements
Module: clk_rst_trace_engine

Interface
REQ-001 Parameter NUM_CH, default 4: number of traced reset/control channels.
REQ-002 Parameter TS_W, default 48: timestamp (cycle counter) width in bits.
REQ-003 Parameter FIFO_DEPTH, default 16: dump event buffer depth; SHALL be a power of 2 and at least 2.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  asynchronous active-low reset.
REQ-006 en  in  1  run enable; rising edge starts a session, low returns to IDLE.
REQ-007 mode  in  1  0 = dump (record), 1 = read (replay); sampled only on the rising edge of en.
REQ-008 sig_in  in  NUM_CH  synchronous channel values to record.
REQ-009 ev_out_valid / ev_out_ready  out / in  1  dump event stream handshake.
REQ-010 ev_out_data  out  TS_W+NUM_CH  {timestamp, channel values}.
REQ-011 ev_in_valid / ev_in_ready  in / out  1  replay event stream handshake.
REQ-012 ev_in_data  in  TS_W+NUM_CH  {timestamp, channel values}.
REQ-013 sig_out  out  NUM_CH  replayed channel values.
REQ-014 clkcnt  out  TS_W  session cycle counter.
REQ-015 ovf_cnt / late_cnt  out  16 each  dropped dump events / late replay events.
REQ-016 busy  out  1  high in any state other than IDLE.

Function
REQ-017 The FSM SHALL have the states IDLE, DUMP, RD_INIT and RD_RUN.
REQ-018 IDLE -> DUMP on an en rise with mode=0; IDLE -> RD_INIT on an en rise with mode=1; any state -> IDLE in the cycle after en is sampled low.
REQ-019 On entering DUMP or RD_INIT: clkcnt SHALL clear to 0, and ovf_cnt and late_cnt SHALL clear.
REQ-020 Entering DUMP SHALL flush the FIFO.
REQ-021 clkcnt SHALL increment by 1 every cycle in DUMP and RD_RUN, hold in all other states, and wrap modulo 2^TS_W.
REQ-022 DUMP, first cycle: SHALL push init event {0, sig_in} unconditionally and load prev = sig_in.
REQ-023 DUMP, later cycles: when sig_in != prev, SHALL push {clkcnt, sig_in} and update prev; simultaneous changes on several channels form one event.
REQ-024 Push accepted when FIFO not full, or when full and a pop occurs in the same cycle.
REQ-025 Otherwise push SHALL be dropped, prev still updated, and ovf_cnt incremented (saturating at 0xFFFF).
REQ-026 ev_out_valid = FIFO not empty; pop when valid && ready; FWFT, data stable while valid && !ready.
REQ-027 Draining SHALL continue in IDLE after en falls.
REQ-028 RD_INIT: ev_in_ready=1; on accepted event, sig_out <= values, clkcnt <= timestamp, -> RD_RUN.
REQ-029 RD_RUN: ev_in_ready SHALL be high only in cycles where ev_in_valid && clkcnt >= timestamp (unsigned); on that handshake sig_out <= values in the same edge.
REQ-030 If timestamp < clkcnt at first presentation, the event SHALL be applied at once and late_cnt incremented (saturating).
REQ-031 Apply latency: sig_out updates on the edge at which clkcnt == timestamp is sampled, i.e. visible 1 cycle later.
REQ-032 sig_out SHALL hold its value in IDLE and DUMP.

Reset
REQ-033 While rst=0: state=IDLE, FIFO empty, clkcnt=0, prev=0, sig_out=0, ovf_cnt=0, late_cnt=0, ev_out_valid=0, ev_in_ready=0, busy=0.
REQ-034 Reset assertion mid-session SHALL abort immediately; buffered events are lost.
REQ-035 After release, the block SHALL require a fresh en rise to start (en high at release is not an edge).

Structure
REQ-036 Package clk_rst_trace_pkg SHALL hold the state enum, the MODE_DUMP/MODE_READ constants and the counter width constant (16).
REQ-037 Sub-module clk_rst_trace_fifo (synchronous FWFT FIFO, parametrised width/depth, full/empty/flush) SHALL be instantiated once.

Verification
REQ-038 NUM_CH=4, dump; sig_in=0x3, toggle to 0x2 at cycle 5 -> events {0,0x3}, {5,0x2}.
REQ-039 Dump, ev_out_ready=0, sig_in changes 20 times with FIFO_DEPTH=16 -> 16 buffered (init + 15), ovf_cnt=5.
REQ-040 FIFO full, change coincides with a pop -> push accepted, ovf_cnt unchanged.
REQ-041 Read; feed {100,0xF}, {103,0x0}, {102,0x5} -> sig_out=0xF with clkcnt=100, 0x0 at 103, 0x5 at 104, late_cnt=1.
REQ-042 Reset pulse during RD_RUN -> sig_out=0, state IDLE, busy=0; with en held high the block stays in IDLE.
REQ-043 TS_W=8, dump for 300 cycles -> clkcnt wraps to 44 and event timestamps wrap accordingly.
